sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller request port between three requesters: video line fetch (read), host pixel writer (write) and host readback (read). It sits between the memory reader/writer logic and the SDRAM controller, all on the memory clock. It grants one burst at a time. An urgent video FIFO pre-empts everything; other requesters are served round-robin with starvation promotion. The grant is held until the whole burst has transferred.

---
 rtl/sdram_port_arbiter_pkg.sv | 38 +++
 rtl/sdram_port_arbiter_arb_pick.sv | 43 ++++
 rtl/sdram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared encodings for the SDRAM port arbiter: grant codes, FSM states and
// requester index helpers.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_HRD  = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam int BURST_LEN_DEF = 8;
    localparam int NUM_REQ       = 3;

    // Requester indices; grant code is always index + 1.
    localparam logic [1:0] IDX_VID = 2'd0;
    localparam logic [1:0] IDX_WR  = 2'd1;
    localparam logic [1:0] IDX_HRD = 2'd2;

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == IDX_HRD) ? IDX_VID : idx + 2'd1;
    endfunction

    function automatic grant_e idx_to_grant(input logic [1:0] idx);
        return grant_e'(idx + 2'd1);
    endfunction

    function automatic logic [1:0] grant_to_idx(input grant_e gnt);
        return 2'(gnt) - 2'd1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_arb_pick.sv
// Combinational winner selection: urgent video, then lowest-index starved
// requester, then round-robin starting at the pointer.
module arb_pick
    import sdram_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_urgent,
    input  logic [NUM_REQ-1:0] i_starved,
    input  logic [1:0]         i_rr_ptr,
    output logic               o_valid,
    output logic [1:0]         o_winner,
    output logic               o_promoted
);

    logic [1:0] w_rot_idx [NUM_REQ];

    // w_rot_idx[k] is the k-th candidate in round-robin order.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [2:0] w_sum;
        assign w_sum         = {1'b0, i_rr_ptr} + 3'(gi);
        assign w_rot_idx[gi] = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    end

    always_comb begin
        o_valid    = |i_req;
        o_winner   = IDX_VID;
        o_promoted = 1'b0;
        if (i_urgent) begin
            o_winner = IDX_VID;
        end else if (|i_starved) begin
            o_promoted = 1'b1;
            if (i_starved[0])      o_winner = IDX_VID;
            else if (i_starved[1]) o_winner = IDX_WR;
            else                   o_winner = IDX_HRD;
        end else begin
            // Walk backwards so the earliest pending candidate is assigned last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (i_req[w_rot_idx[k]]) o_winner = w_rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller request port between video fetch, host write and
// host readback; one burst per grant, grant held until the last beat.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int         BURST_LEN    = BURST_LEN_DEF,
    parameter logic [1:0] URGENT_LEVEL = 2'b01,
    parameter int         STARVE_LIMIT = 64
) (
    input  logic        mem_clk,
    input  logic        reset,
    input  logic        vid_rd_req,
    input  logic [24:0] vid_rd_addr,
    input  logic [1:0]  vid_fifo_level,
    output logic        vid_ack,
    input  logic        wr_req,
    input  logic [24:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        wr_data_next,
    input  logic        hrd_req,
    input  logic [24:0] hrd_addr,
    output logic        hrd_ack,
    output logic        hrd_data_valid,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [24:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_ack,
    input  logic        mem_wr_data_next,
    input  logic        mem_rd_data_valid,
    output logic [1:0]  grant,
    output logic        starve_evt
);

    localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);

    state_e      r_state;
    grant_e      r_grant;
    logic        r_is_write;
    logic        r_mem_rd_req;
    logic        r_mem_wr_req;
    logic [24:0] r_mem_addr;
    logic [3:0]  r_beat_cnt;
    logic [1:0]  r_rr_ptr;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_starved;
    logic [NUM_REQ-1:0] w_served;
    logic               w_urgent;
    logic               w_pick_valid;
    logic [1:0]         w_pick_idx;
    logic               w_pick_promoted;
    logic               w_decide;
    logic [24:0]        w_pick_addr;
    logic               w_beat;
    logic [3:0]         w_cnt_now;
    logic               w_last_beat;

    assign w_req    = {hrd_req, wr_req, vid_rd_req};
    assign w_urgent = vid_rd_req && (vid_fifo_level <= URGENT_LEVEL);

    arb_pick u_pick (
        .i_req      (w_req),
        .i_urgent   (w_urgent),
        .i_starved  (w_starved),
        .i_rr_ptr   (r_rr_ptr),
        .o_valid    (w_pick_valid),
        .o_winner   (w_pick_idx),
        .o_promoted (w_pick_promoted)
    );

    assign w_decide = (r_state == ST_IDLE) && w_pick_valid;

    // Per-requester wait counters, saturating at 8 bits.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
        logic [7:0] r_cnt;

        assign w_served[gi]  = (r_grant == idx_to_grant(2'(gi)))
                             || (w_decide && (w_pick_idx == 2'(gi)));
        assign w_starved[gi] = w_req[gi] && (int'(r_cnt) >= STARVE_LIMIT);

        always_ff @(posedge mem_clk) begin
            if (reset) begin
                r_cnt <= 8'd0;
            end else if (!w_req[gi] || w_served[gi]) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_pick_addr = vid_rd_addr;
        case (w_pick_idx)
            IDX_WR:  w_pick_addr = wr_addr;
            IDX_HRD: w_pick_addr = hrd_addr;
            default: w_pick_addr = vid_rd_addr;
        endcase
    end

    // A beat accompanying mem_ack counts as the first beat of the burst.
    assign w_beat      = r_is_write ? mem_wr_data_next : mem_rd_data_valid;
    assign w_cnt_now   = (r_state == ST_ISSUE) ? 4'd0 : r_beat_cnt;
    assign w_last_beat = w_beat && (w_cnt_now == BEAT_LAST);

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_NONE;
            r_is_write   <= 1'b0;
            r_mem_rd_req <= 1'b0;
            r_mem_wr_req <= 1'b0;
            r_mem_addr   <= 25'd0;
            r_beat_cnt   <= 4'd0;
            r_rr_ptr     <= IDX_VID;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant      <= idx_to_grant(w_pick_idx);
                        r_mem_addr   <= w_pick_addr;
                        r_is_write   <= (w_pick_idx == IDX_WR);
                        r_mem_wr_req <= (w_pick_idx == IDX_WR);
                        r_mem_rd_req <= (w_pick_idx != IDX_WR);
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        r_mem_rd_req <= 1'b0;
                        r_mem_wr_req <= 1'b0;
                        if (w_last_beat) begin
                            r_state    <= ST_IDLE;
                            r_grant    <= GNT_NONE;
                            r_rr_ptr   <= wrap_inc(grant_to_idx(r_grant));
                            r_beat_cnt <= 4'd0;
                        end else begin
                            r_state    <= ST_BURST;
                            r_beat_cnt <= w_beat ? 4'd1 : 4'd0;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_last_beat) begin
                        r_state    <= ST_IDLE;
                        r_grant    <= GNT_NONE;
                        r_rr_ptr   <= wrap_inc(grant_to_idx(r_grant));
                        r_beat_cnt <= 4'd0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign mem_rd_req = r_mem_rd_req;
    assign mem_wr_req = r_mem_wr_req;
    assign mem_addr   = r_mem_addr;
    assign starve_evt = w_decide && w_pick_promoted;

    assign vid_ack = mem_ack && (r_state == ST_ISSUE) && (r_grant == GNT_VID);
    assign wr_ack  = mem_ack && (r_state == ST_ISSUE) && (r_grant == GNT_WR);
    assign hrd_ack = mem_ack && (r_state == ST_ISSUE) && (r_grant == GNT_HRD);

    assign wr_data_next   = mem_wr_data_next && (r_grant == GNT_WR);
    assign hrd_data_valid = mem_rd_data_valid && (r_grant == GNT_HRD);
    assign mem_wr_data    = (r_grant == GNT_WR) ? wr_data : 32'd0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: write burst timing, urgent priority,
// rotation, starvation promotion, mid-burst reset and ack-with-beat.
module tb_sdram_port_arbiter;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic        vid_rd_req;
    logic [24:0] vid_rd_addr;
    logic [1:0]  vid_fifo_level;
    logic        vid_ack;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        wr_data_next;
    logic        hrd_req;
    logic [24:0] hrd_addr;
    logic        hrd_ack;
    logic        hrd_data_valid;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [24:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_ack;
    logic        mem_wr_data_next;
    logic        mem_rd_data_valid;
    logic [1:0]  grant;
    logic        starve_evt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 mem_clk = ~mem_clk;

    sdram_port_arbiter #(
        .BURST_LEN    (8),
        .URGENT_LEVEL (2'b01),
        .STARVE_LIMIT (16)
    ) dut (
        .mem_clk           (mem_clk),
        .reset             (reset),
        .vid_rd_req        (vid_rd_req),
        .vid_rd_addr       (vid_rd_addr),
        .vid_fifo_level    (vid_fifo_level),
        .vid_ack           (vid_ack),
        .wr_req            (wr_req),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_ack            (wr_ack),
        .wr_data_next      (wr_data_next),
        .hrd_req           (hrd_req),
        .hrd_addr          (hrd_addr),
        .hrd_ack           (hrd_ack),
        .hrd_data_valid    (hrd_data_valid),
        .mem_rd_req        (mem_rd_req),
        .mem_wr_req        (mem_wr_req),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_ack           (mem_ack),
        .mem_wr_data_next  (mem_wr_data_next),
        .mem_rd_data_valid (mem_rd_data_valid),
        .grant             (grant),
        .starve_evt        (starve_evt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Serve one burst as the controller; the bench stands in for the requesters.
    task automatic run_burst(input logic [1:0] exp_gnt, input logic [24:0] exp_addr,
                             input bit keep, input string tag);
        int t = 0;
        while (!(mem_rd_req || mem_wr_req) && t < 40) begin
            tick();
            t++;
        end
        chk({tag, "_issue"}, 32'(mem_rd_req | mem_wr_req), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_dir"}, 32'(mem_wr_req), 32'(exp_gnt == 2'd2));
        mem_ack = 1'b1;
        #1;
        case (exp_gnt)
            2'd1:    chk({tag, "_ack"}, 32'(vid_ack), 32'd1);
            2'd2:    chk({tag, "_ack"}, 32'(wr_ack), 32'd1);
            default: chk({tag, "_ack"}, 32'(hrd_ack), 32'd1);
        endcase
        tick();
        mem_ack = 1'b0;
        if (!keep) begin
            case (exp_gnt)
                2'd1:    vid_rd_req = 1'b0;
                2'd2:    wr_req     = 1'b0;
                default: hrd_req    = 1'b0;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (exp_gnt == 2'd2) mem_wr_data_next = 1'b1;
            else                 mem_rd_data_valid = 1'b1;
            #1;
            chk({tag, "_wnext"}, 32'(wr_data_next), 32'(exp_gnt == 2'd2));
            chk({tag, "_hvalid"}, 32'(hrd_data_valid), 32'(exp_gnt == 2'd3));
            tick();
        end
        mem_wr_data_next  = 1'b0;
        mem_rd_data_valid = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(grant), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        vid_rd_req = 1'b0; vid_rd_addr = 25'd0; vid_fifo_level = 2'b11;
        wr_req = 1'b0; wr_addr = 25'd0; wr_data = 32'd0;
        hrd_req = 1'b0; hrd_addr = 25'd0;
        mem_ack = 1'b0; mem_wr_data_next = 1'b0; mem_rd_data_valid = 1'b0;
        do_reset();

        // Reset state.
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rdreq", 32'(mem_rd_req), 32'd0);
        chk("rst_wrreq", 32'(mem_wr_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_starve", 32'(starve_evt), 32'd0);

        // Single write burst, controller acks three cycles after the request.
        wr_req = 1'b1; wr_addr = 25'h0001000; wr_data = 32'hA5A5_0001;
        #1;
        chk("t1_idle_req", 32'(mem_wr_req), 32'd0);
        tick();
        chk("t1_wrreq", 32'(mem_wr_req), 32'd1);
        chk("t1_rdreq", 32'(mem_rd_req), 32'd0);
        chk("t1_addr", 32'(mem_addr), 32'h0001000);
        chk("t1_grant", 32'(grant), 32'd2);
        chk("t1_wdata", mem_wr_data, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) begin
            chk("t1_noack", 32'(wr_ack), 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        chk("t1_ack", 32'(wr_ack), 32'd1);
        chk("t1_vack", 32'(vid_ack), 32'd0);
        tick();
        mem_ack = 1'b0; wr_req = 1'b0;
        #1;
        chk("t1_ack_pulse", 32'(wr_ack), 32'd0);
        chk("t1_wrreq_low", 32'(mem_wr_req), 32'd0);
        for (int i = 0; i < 8; i++) begin
            mem_wr_data_next = 1'b1;
            #1;
            chk("t1_wnext", 32'(wr_data_next), 32'd1);
            chk("t1_hold", 32'(grant), 32'd2);
            tick();
        end
        mem_wr_data_next = 1'b0;
        #1;
        chk("t1_end", 32'(grant), 32'd0);
        tick();
        chk("t1_stay_idle", 32'(grant), 32'd0);

        // Video-only burst moves the round-robin pointer on to the writer.
        vid_rd_req = 1'b1; vid_rd_addr = 25'h0000040; vid_fifo_level = 2'b11;
        run_burst(2'd1, 25'h0000040, 1'b0, "vid0");

        // Urgent video beats a writer that round-robin would favour.
        vid_rd_req = 1'b1; vid_rd_addr = 25'h00ABCDE; vid_fifo_level = 2'b00;
        wr_req = 1'b1; wr_addr = 25'h0002000; wr_data = 32'h1234_5678;
        #1;
        tick();
        chk("t2_rdreq", 32'(mem_rd_req), 32'd1);
        chk("t2_wrreq", 32'(mem_wr_req), 32'd0);
        chk("t2_wdata0", mem_wr_data, 32'd0);
        run_burst(2'd1, 25'h00ABCDE, 1'b0, "t2v");
        run_burst(2'd2, 25'h0002000, 1'b0, "t2w");

        // All three requesting, nobody urgent: rotation video, write, readback, video.
        do_reset();
        vid_rd_req = 1'b1; vid_rd_addr = 25'h0000100; vid_fifo_level = 2'b11;
        wr_req = 1'b1; wr_addr = 25'h0000200;
        hrd_req = 1'b1; hrd_addr = 25'h0000300;
        run_burst(2'd1, 25'h0000100, 1'b1, "rr1");
        run_burst(2'd2, 25'h0000200, 1'b1, "rr2");
        run_burst(2'd3, 25'h0000300, 1'b1, "rr3");
        run_burst(2'd1, 25'h0000100, 1'b1, "rr4");
        vid_rd_req = 1'b0; wr_req = 1'b0; hrd_req = 1'b0;

        // Readback starved behind urgent video, promoted once its count reaches 16.
        do_reset();
        vid_rd_req = 1'b1; vid_rd_addr = 25'h0000500; vid_fifo_level = 2'b00;
        hrd_req = 1'b1; hrd_addr = 25'h0000600;
        #1;
        chk("st1_evt", 32'(starve_evt), 32'd0);
        run_burst(2'd1, 25'h0000500, 1'b1, "st1");
        #1;
        chk("st2_evt", 32'(starve_evt), 32'd0);
        run_burst(2'd1, 25'h0000500, 1'b1, "st2");
        vid_fifo_level = 2'b11;
        #1;
        chk("st3_evt", 32'(starve_evt), 32'd1);
        run_burst(2'd3, 25'h0000600, 1'b0, "st3");
        vid_rd_req = 1'b0;

        // Reset after the 4th write beat aborts the burst.
        do_reset();
        wr_req = 1'b1; wr_addr = 25'h0007000; wr_data = 32'hCAFE_0000;
        tick();
        chk("rb_wrreq", 32'(mem_wr_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_wr_data_next = 1'b1;
            tick();
        end
        mem_wr_data_next = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rb_grant", 32'(grant), 32'd0);
        chk("rb_wrreq0", 32'(mem_wr_req), 32'd0);
        chk("rb_addr", 32'(mem_addr), 32'd0);
        chk("rb_wdata", mem_wr_data, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_wr_data_next = 1'b1;
            #1;
            chk("rb_wnext", 32'(wr_data_next), 32'd0);
            tick();
        end
        mem_wr_data_next = 1'b0;

        // mem_ack together with the first read beat: eight beats total.
        do_reset();
        hrd_req = 1'b1; hrd_addr = 25'h0009000;
        tick();
        chk("ab_rdreq", 32'(mem_rd_req), 32'd1);
        mem_ack = 1'b1; mem_rd_data_valid = 1'b1;
        #1;
        chk("ab_ack", 32'(hrd_ack), 32'd1);
        chk("ab_valid", 32'(hrd_data_valid), 32'd1);
        tick();
        mem_ack = 1'b0; hrd_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("ab_hold", 32'(grant), 32'd3);
            tick();
        end
        mem_rd_data_valid = 1'b0;
        #1;
        chk("ab_end8", 32'(grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
